mac_table_arbiter: RTL and testbench

Shares one single-port MAC learning table (`ram`, `MEM_WIDTH` x `MEM_DEPTH`) between `NUM_REQ` Ethernet parser ports. Each port issues lookup (read) or learn (write) requests; the block grants one per cycle round-robin, drives the RAM, and returns read data tagged to the originating port. After reset, and on `i_flush`, it sweeps the table and clears every valid bit. It sits between the per-port L2 parsers and a shared `mac_table` instance.

---
 rtl/mac_table_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mac_table_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_table_arbiter.sv
// mac_table_arbiter
//   Shares one single-port MAC learning table between NUM_REQ parser ports.
//   One request is granted per cycle in round-robin order. The block drives
//   the RAM command and returns lookup data tagged to the port that asked.
//   After reset, and on i_flush, it sweeps the whole table, writing 0 to every
//   entry so that all valid bits are cleared.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   i_req_valid/wr       : per-port request pending / 1 = learn, 0 = lookup
//   i_req_addr/data      : packed per-port address / write data
//   o_req_grant          : one-hot, request accepted this cycle
//   o_rsp_valid          : one-hot, lookup result valid for that port
//   o_rsp_data           : shared lookup result (0 when no response is valid)
//   i_flush              : single-cycle pulse that starts a table clear
//   o_busy               : high while the clear sweep is running
//   o_mem_addr/data/wren/rden : registered RAM command
//   i_mem_q              : RAM read data, valid RD_LATENCY cycles after rden
module mac_table_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int MEM_DEPTH  = 512,
  parameter  int NOC_RADIX  = 16,
  parameter  int MEM_WIDTH  = $clog2(NOC_RADIX) + 1,
  parameter  int RD_LATENCY = 2,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ-1:0]           i_req_wr,
  input  logic [NUM_REQ*AW-1:0]        i_req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_grant,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [MEM_WIDTH-1:0]         o_rsp_data,
  input  logic                         i_flush,
  output logic                         o_busy,
  output logic [AW-1:0]                o_mem_addr,
  output logic [MEM_WIDTH-1:0]         o_mem_data,
  output logic                         o_mem_wren,
  output logic                         o_mem_rden,
  input  logic [MEM_WIDTH-1:0]         i_mem_q
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {FLUSH, ARB} state_t;

  state_t                        state_q;
  logic [AW-1:0]                 flush_cnt_q;
  logic [IDW-1:0]                ptr_q;

  logic [AW-1:0]                 mem_addr_q;
  logic [MEM_WIDTH-1:0]          mem_data_q;
  logic                          mem_wren_q;
  logic                          mem_rden_q;

  // Tag pipeline: stage 0 is loaded with the grant, stage RD_LATENCY lines up
  // with the RAM output for that request.
  logic [RD_LATENCY:0]           tag_vld_q;
  logic [RD_LATENCY:0][IDW-1:0]  tag_id_q;

  // Combinational arbitration result
  logic                          gnt_any_d;
  logic [IDW-1:0]                gnt_id_d;
  logic                          sel_wr_d;
  logic [AW-1:0]                 sel_addr_d;
  logic [MEM_WIDTH-1:0]          sel_data_d;
  logic [IDW-1:0]                ptr_d;

  // Scan from the pointer upward (mod NUM_REQ); the first valid port wins.
  always_comb begin
    int idx;
    idx        = 0;
    gnt_any_d  = 1'b0;
    gnt_id_d   = '0;
    sel_wr_d   = 1'b0;
    sel_addr_d = '0;
    sel_data_d = '0;
    if (state_q == ARB) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(ptr_q) + i) % NUM_REQ;
        if (!gnt_any_d && i_req_valid[idx]) begin
          gnt_any_d  = 1'b1;
          gnt_id_d   = IDW'(idx);
          sel_wr_d   = i_req_wr[idx];
          sel_addr_d = i_req_addr[idx*AW +: AW];
          sel_data_d = i_req_data[idx*MEM_WIDTH +: MEM_WIDTH];
        end
      end
    end
  end

  assign ptr_d = (gnt_id_d == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_d + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      // Idle command unless something below loads it.
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      mem_rden_q <= 1'b0;

      // Tags shift every cycle, including during a flush, so lookups that
      // were already granted still return their data.
      tag_vld_q[0] <= gnt_any_d && !sel_wr_d;
      tag_id_q[0]  <= gnt_id_d;
      for (int s = 1; s <= RD_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end

      case (state_q)
        FLUSH: begin
          // i_flush is deliberately ignored here: the sweep is not restarted.
          mem_wren_q  <= 1'b1;
          mem_addr_q  <= flush_cnt_q;
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == AW'(MEM_DEPTH - 1)) begin
            state_q <= ARB;
          end
        end
        ARB: begin
          // The grant in the same cycle as i_flush is still honoured; the
          // sweep starts issuing writes the cycle after.
          if (gnt_any_d) begin
            mem_wren_q <= sel_wr_d;
            mem_rden_q <= !sel_wr_d;
            mem_addr_q <= sel_addr_d;
            mem_data_q <= sel_wr_d ? sel_data_d : '0;
            ptr_q      <= ptr_d;
          end
          if (i_flush) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
          end
        end
        default: state_q <= FLUSH;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign o_req_grant[gi] = gnt_any_d && (gnt_id_d == IDW'(gi));
      assign o_rsp_valid[gi] = tag_vld_q[RD_LATENCY] &&
                               (tag_id_q[RD_LATENCY] == IDW'(gi));
    end
  endgenerate

  assign o_rsp_data = tag_vld_q[RD_LATENCY] ? i_mem_q : '0;
  assign o_busy     = (state_q == FLUSH);
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_wren = mem_wren_q;
  assign o_mem_rden = mem_rden_q;

endmodule

// File: tb/tb_mac_table_arbiter.sv
// tb_mac_table_arbiter
//   Directed bench for mac_table_arbiter with a behavioural single-port RAM
//   (2-cycle read latency, write committed at the clock edge).
//   Inputs change 1 ns after the rising edge, outputs are sampled on the
//   falling edge of the same cycle.
module tb_mac_table_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int MEM_DEPTH  = 512;
  localparam int NOC_RADIX  = 16;
  localparam int MEM_WIDTH  = 5;
  localparam int RD_LATENCY = 2;
  localparam int AW         = 9;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic [NUM_REQ-1:0]           i_req_valid = '0;
  logic [NUM_REQ-1:0]           i_req_wr = '0;
  logic [NUM_REQ*AW-1:0]        i_req_addr = '0;
  logic [NUM_REQ*MEM_WIDTH-1:0] i_req_data = '0;
  logic [NUM_REQ-1:0]           o_req_grant;
  logic [NUM_REQ-1:0]           o_rsp_valid;
  logic [MEM_WIDTH-1:0]         o_rsp_data;
  logic                         i_flush = 1'b0;
  logic                         o_busy;
  logic [AW-1:0]                o_mem_addr;
  logic [MEM_WIDTH-1:0]         o_mem_data;
  logic                         o_mem_wren;
  logic                         o_mem_rden;
  logic [MEM_WIDTH-1:0]         i_mem_q;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mac_table_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MEM_DEPTH (MEM_DEPTH),
    .NOC_RADIX (NOC_RADIX),
    .MEM_WIDTH (MEM_WIDTH),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req_valid(i_req_valid),
    .i_req_wr   (i_req_wr),
    .i_req_addr (i_req_addr),
    .i_req_data (i_req_data),
    .o_req_grant(o_req_grant),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data (o_rsp_data),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_wren (o_mem_wren),
    .o_mem_rden (o_mem_rden),
    .i_mem_q    (i_mem_q)
  );

  // Behavioural RAM: write at the edge, read data two cycles after rden.
  logic [MEM_WIDTH-1:0] ram [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] rd_q1, rd_q2;
  always @(posedge clk) begin
    if (o_mem_wren) ram[o_mem_addr] <= o_mem_data;
    rd_q1 <= ram[o_mem_addr];
    rd_q2 <= rd_q1;
  end
  assign i_mem_q = rd_q2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, act);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic wr, input int addr, input int data);
    i_req_valid[k]                     = 1'b1;
    i_req_wr[k]                        = wr;
    i_req_addr[k*AW +: AW]             = AW'(addr);
    i_req_data[k*MEM_WIDTH +: MEM_WIDTH] = MEM_WIDTH'(data);
  endtask

  logic [NUM_REQ-1:0]   gr_log [9];
  logic [NUM_REQ-1:0]   rv_log [9];
  logic [MEM_WIDTH-1:0] rd_log [9];
  int bad;

  initial begin
    // ---------------- 1. reset and post-reset flush ----------------
    next_cycle();
    sample();
    check("rst_grant", 32'(o_req_grant), 32'h0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(o_rsp_data), 32'h0);
    check("rst_mem_cmd", {o_mem_wren, o_mem_rden, 7'd0, o_mem_addr, 8'd0, o_mem_data}, 32'h0);
    check("rst_busy", 32'(o_busy), 32'h1);
    next_cycle();
    reset = 1'b0;                       // cycle r
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, 16 + k, 0);
    sample();
    check("r_idle_wren", 32'(o_mem_wren), 32'h0);
    bad = 0;
    for (int k = 0; k < MEM_DEPTH; k++) begin
      next_cycle();                     // cycle r+1+k
      sample();
      if (o_mem_wren !== 1'b1 || o_mem_rden !== 1'b0 ||
          o_mem_addr !== AW'(k) || o_mem_data !== '0) bad++;
      if (k < MEM_DEPTH - 1 && o_req_grant !== '0) bad++;
      if (k == MEM_DEPTH - 2) check("busy_before_end", 32'(o_busy), 32'h1);
      if (k == MEM_DEPTH - 1) check("busy_fall", 32'(o_busy), 32'h0);
    end
    check("flush_sweep_errors", 32'(bad), 32'h0);

    // ---------------- 2. round-robin, all ports reading ----------------
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        next_cycle();
        if (i == 5) i_req_valid = '0;
        sample();
      end
      gr_log[i] = o_req_grant;
      rv_log[i] = o_rsp_valid;
      rd_log[i] = o_rsp_data;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant%0d", i), 32'(gr_log[i]), 32'(1 << (i % 4)));
      check($sformatf("rr_rsp%0d", i), 32'(rv_log[i+3]), 32'(1 << (i % 4)));
      check($sformatf("rr_data%0d", i), 32'(rd_log[i+3]), 32'h0);
    end
    check("rr_no_early_rsp", 32'(rv_log[0] | rv_log[1] | rv_log[2]), 32'h0);
    check("rr_no_grant_idle", 32'(gr_log[5] | gr_log[6] | gr_log[7] | gr_log[8]), 32'h0);

    // ---------------- 4. sparse requests, pointer at 1 ----------------
    next_cycle();
    set_req(0, 1'b0, 32, 0);
    set_req(3, 1'b0, 35, 0);
    sample();
    check("sparse_grant_a", 32'(o_req_grant), 32'h8);
    next_cycle();
    i_req_valid = 4'b0001;
    sample();
    check("sparse_grant_b", 32'(o_req_grant), 32'h1);
    next_cycle();
    i_req_valid = '0;
    next_cycle();
    sample();
    check("sparse_rsp_a", 32'(o_rsp_valid), 32'h8);
    next_cycle();
    sample();
    check("sparse_rsp_b", 32'(o_rsp_valid), 32'h1);

    // ---------------- 3. learn then lookup ----------------
    next_cycle();                       // cycle L, pointer at 1
    set_req(2, 1'b1, 'h1A3, 'h15);
    sample();
    check("learn_grant", 32'(o_req_grant), 32'h4);
    next_cycle();                       // L+1
    i_req_valid = '0;
    set_req(0, 1'b0, 'h1A3, 0);
    sample();
    check("lookup_grant", 32'(o_req_grant), 32'h1);
    check("learn_cmd", {o_mem_wren, o_mem_rden, 14'd0, 7'd0, o_mem_addr}, {2'b10, 14'd0, 7'd0, 9'h1A3});
    check("learn_data", 32'(o_mem_data), 32'h15);
    next_cycle();                       // L+2
    i_req_valid = '0;
    sample();
    check("lookup_cmd", {o_mem_wren, o_mem_rden, 14'd0, 7'd0, o_mem_addr}, {2'b01, 14'd0, 7'd0, 9'h1A3});
    next_cycle();                       // L+3
    sample();
    check("lookup_not_yet", 32'(o_rsp_valid), 32'h0);
    next_cycle();                       // L+4
    sample();
    check("lookup_rsp_valid", 32'(o_rsp_valid), 32'h1);
    check("lookup_rsp_data", 32'(o_rsp_data), 32'h15);

    // ---------------- 5. flush with a lookup in flight ----------------
    next_cycle();                       // cycle F, pointer at 1
    set_req(1, 1'b0, 'h1A3, 0);
    i_flush = 1'b1;
    sample();
    check("flush_same_cycle_grant", 32'(o_req_grant), 32'h2);
    check("flush_busy_f", 32'(o_busy), 32'h0);
    next_cycle();                       // F+1
    i_req_valid = '0;
    i_flush = 1'b0;
    sample();
    check("flush_busy_rise", 32'(o_busy), 32'h1);
    check("flush_inflight_cmd", {o_mem_rden, 22'd0, o_mem_addr}, {1'b1, 22'd0, 9'h1A3});
    next_cycle();                       // F+2
    sample();
    check("flush_first_write", {o_mem_wren, 22'd0, o_mem_addr}, {1'b1, 22'd0, 9'h000});
    next_cycle();                       // F+3
    sample();
    check("flush_inflight_rsp", 32'(o_rsp_valid), 32'h2);
    check("flush_inflight_data", 32'(o_rsp_data), 32'h15);
    next_cycle();                       // F+4: pulse while busy
    i_flush = 1'b1;
    next_cycle();                       // F+5
    i_flush = 1'b0;
    for (int c = 6; c <= MEM_DEPTH; c++) next_cycle();   // F+512
    sample();
    check("reflush_busy_hold", 32'(o_busy), 32'h1);
    next_cycle();                       // F+513
    set_req(3, 1'b0, 'h1A3, 0);
    sample();
    check("reflush_busy_fall", 32'(o_busy), 32'h0);
    check("post_flush_grant", 32'(o_req_grant), 32'h8);
    next_cycle();
    i_req_valid = '0;
    next_cycle();
    next_cycle();                       // F+516
    sample();
    check("post_flush_rsp", 32'(o_rsp_valid), 32'h8);
    check("post_flush_cleared", 32'(o_rsp_data), 32'h0);

    // ---------------- 6. reset with a lookup in flight ----------------
    next_cycle();                       // cycle G, pointer at 0
    set_req(0, 1'b0, 5, 0);
    sample();
    check("rst_inflight_grant", 32'(o_req_grant), 32'h1);
    next_cycle();                       // G+1
    i_req_valid = '0;
    reset = 1'b1;
    next_cycle();                       // G+2
    reset = 1'b0;
    sample();
    check("rst2_cmd_idle", {o_mem_wren, o_mem_rden}, 32'h0);
    check("rst2_busy", 32'(o_busy), 32'h1);
    check("rst2_rsp_g2", 32'(o_rsp_valid), 32'h0);
    next_cycle();                       // G+3: where the response would have been
    sample();
    check("rst2_rsp_dropped", 32'(o_rsp_valid), 32'h0);
    check("rst2_sweep_addr0", {o_mem_wren, 22'd0, o_mem_addr}, {1'b1, 22'd0, 9'h000});
    next_cycle();                       // G+4
    sample();
    check("rst2_sweep_addr1", {o_mem_wren, 22'd0, o_mem_addr}, {1'b1, 22'd0, 9'h001});
    check("rst2_rsp_g4", 32'(o_rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
